// File: rtl/regfile_pkg.sv
// Shared configuration for the rename-aware register file: bus widths,
// reserved names and the packed bundles passed between top and read ports.
package regfile_pkg;

  localparam int RegNum  = 32;
  localparam int NameBus = 5;
  localparam int DataBus = 32;
  localparam int NickBus = 5;

  localparam logic [NickBus-1:0] NoNick  = '0;
  localparam logic [NameBus-1:0] ZeroReg = '0;

  typedef logic [NameBus-1:0] reg_name_t;
  typedef logic [DataBus-1:0] data_t;
  typedef logic [NickBus-1:0] nick_t;

  typedef logic [RegNum-1:0][DataBus-1:0] data_array_t;
  typedef logic [RegNum-1:0][NickBus-1:0] tag_array_t;

  // Commit broadcast from the ROB, shared by both read ports for forwarding.
  typedef struct packed {
    logic      en;
    reg_name_t regnm;
    nick_t     nick;
    data_t     dt;
  } commit_t;

  function automatic logic is_writable(input reg_name_t regnm);
    return regnm != ZeroReg;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational operand lookup: returns value or pending producer nick,
// with same-cycle forwarding from a matching commit.
module regfile_rdport
  import regfile_pkg::*;
(
  input  logic [NameBus-1:0] regnm,
  input  data_array_t        data_q,
  input  tag_array_t         tag_q,
  input  commit_t            commit,
  output logic               busy,
  output logic [NickBus-1:0] nick,
  output logic [DataBus-1:0] dt
);

  nick_t cur_tag;
  data_t cur_data;
  logic  fwd_hit;

  assign cur_tag  = tag_q[regnm];
  assign cur_data = data_q[regnm];
  // Only the commit of the current owner clears busy; an older producer's
  // commit must not hide a newer rename.
  assign fwd_hit  = commit.en && (commit.regnm == regnm) && (cur_tag == commit.nick);

  always_comb begin
    busy = 1'b0;
    nick = NoNick;
    dt   = '0;
    if (regnm == ZeroReg) begin
      busy = 1'b0;
    end else if (fwd_hit) begin
      dt = commit.dt;
    end else if (cur_tag != NoNick) begin
      busy = 1'b1;
      nick = cur_tag;
    end else begin
      dt = cur_data;
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags: tracks which in-flight ROB
// entry owns each register and serves two dispatch operand reads.
module regfile
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clr,
  input  logic               iROB_nick_en,
  input  logic [NickBus-1:0] iROB_nick,
  input  logic [NameBus-1:0] iROB_nick_regnm,
  input  logic               iROB_en,
  input  logic [NameBus-1:0] iROB_rd_regnm,
  input  logic [DataBus-1:0] iROB_rd_dt,
  input  logic [NickBus-1:0] iROB_rd_nick,
  input  logic [NameBus-1:0] iDP_rs1_regnm,
  input  logic [NameBus-1:0] iDP_rs2_regnm,
  output logic               oDP_rs1_busy,
  output logic               oDP_rs2_busy,
  output logic [NickBus-1:0] oDP_rs1_nick,
  output logic [NickBus-1:0] oDP_rs2_nick,
  output logic [DataBus-1:0] oDP_rs1_dt,
  output logic [DataBus-1:0] oDP_rs2_dt
);

  data_array_t data_q;
  tag_array_t  tag_q;
  commit_t     commit;

  logic do_commit;
  logic do_rename;

  assign commit = '{en: iROB_en, regnm: iROB_rd_regnm, nick: iROB_rd_nick, dt: iROB_rd_dt};

  assign do_commit = iROB_en && is_writable(iROB_rd_regnm);
  assign do_rename = iROB_nick_en && !clr && is_writable(iROB_nick_regnm);

  // Update order matters: commit clears its own tag, a same-cycle rename then
  // overrides that clear, and a flush overrides every tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      tag_q  <= '0;
    end else if (rdy) begin
      if (do_commit) begin
        data_q[iROB_rd_regnm] <= iROB_rd_dt;
        if (tag_q[iROB_rd_regnm] == iROB_rd_nick)
          tag_q[iROB_rd_regnm] <= NoNick;
      end
      if (do_rename)
        tag_q[iROB_nick_regnm] <= iROB_nick;
      if (clr)
        tag_q <= '0;
    end
  end

  regfile_rdport u_rs1 (
    .regnm  (iDP_rs1_regnm),
    .data_q (data_q),
    .tag_q  (tag_q),
    .commit (commit),
    .busy   (oDP_rs1_busy),
    .nick   (oDP_rs1_nick),
    .dt     (oDP_rs1_dt)
  );

  regfile_rdport u_rs2 (
    .regnm  (iDP_rs2_regnm),
    .data_q (data_q),
    .tag_q  (tag_q),
    .commit (commit),
    .busy   (oDP_rs2_busy),
    .nick   (oDP_rs2_nick),
    .dt     (oDP_rs2_dt)
  );

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global ready; low = hold all state, no updates.
REQ-004 clr  input  1  misprediction flush from ROB; clears all rename tags.
REQ-005 iROB_nick_en  input  1  rename strobe: an in-flight instruction now owns a register.
REQ-006 iROB_nick  input  5  ROB nick (1..31) of that instruction; 0 is reserved and means "no tag".
REQ-007 iROB_nick_regnm  input  5  architectural destination register being renamed.
REQ-008 iROB_en  input  1  commit strobe.
REQ-009 iROB_rd_regnm  input  5  committed destination register.
REQ-010 iROB_rd_dt  input  32  committed value.
REQ-011 iROB_rd_nick  input  5  nick of the committing entry.
REQ-012 iDP_rs1_regnm / iDP_rs2_regnm  input  5 each  source register names from dispatch.
REQ-013 oDP_rs1_busy / oDP_rs2_busy  output  1 each  1 = operand is pending, so wait on the nick.
REQ-014 oDP_rs1_nick / oDP_rs2_nick  output  5 each  pending producer nick; 0 when not busy.
REQ-015 oDP_rs1_dt / oDP_rs2_dt  output  32 each  operand value; valid when busy=0, otherwise 0.

Function
REQ-016 State: data[0..31] (32 bit each) and tag[0..31] (5 bit each); tag 0 = value architecturally current.
REQ-017 Register x0: reads as data 0, busy 0, nick 0; renames and commits targeting x0 are ignored.
REQ-018 Read ports are combinational, with zero latency, computed from registered state and the current-cycle commit only.
REQ-019 The current-cycle rename is invisible to both reads in that cycle, so an instruction reading its own rd sees the older producer.
REQ-020 Commit forwarding: if iROB_en, the register name matches rsX, and tag[rsX]==iROB_rd_nick, then busy=0, nick=0, dt=iROB_rd_dt in the same cycle.
REQ-021 Read without forwarding: busy=(tag!=0), nick=tag, and dt=data when not busy, otherwise 0.
REQ-022 Commit (iROB_en, rdy, regnm!=0): data[regnm] <= iROB_rd_dt unconditionally.
REQ-023 On the same commit, tag[regnm] <= 0 only if tag[regnm]==iROB_rd_nick; a newer owner keeps its tag.
REQ-024 Rename (iROB_nick_en, rdy, !clr, regnm!=0): tag[regnm] <= iROB_nick.
REQ-025 Rename and commit to the same register in the same cycle: the rename tag wins, and the data write still occurs.
REQ-026 clr (with rdy): all tags <= 0 next cycle; a same-cycle commit still writes data; a same-cycle rename is dropped.
REQ-027 rdy=0: no data or tag change; read outputs stay combinationally valid.
REQ-028 Nick wrap 31 to 1 needs no special handling; tags are compared by equality only.

Reset
REQ-029 On rst: all data <= 0 and all tags <= 0; rst has priority over clr, rdy, commit and rename.
REQ-030 After reset, every read port outputs busy=0, nick=0, dt=0.
REQ-031 rst asserted mid-operation discards any pending rename and commit in that cycle.

Structure
REQ-032 Shared config package holds RegNum (32), NameBus (5), DataBus (32), NickBus (5), NoNick (0) and ZeroReg (0).
REQ-033 One sub-module, regfile_rdport, implements the lookup and forwarding of REQ-017..REQ-021 and is instantiated twice (rs1, rs2).
REQ-034 No other sub-modules; tag and data arrays are local registers.

Verification
REQ-035 Reset, then read x5/x6 -> busy=0, nick=0, dt=0 on both ports.
REQ-036 Rename x5 to nick 3, next cycle read x5 -> busy=1, nick=3; commit x5 with dt 0xDEAD and nick 3 -> the same-cycle read gives busy=0, dt=0xDEAD, and the tag is 0 next cycle.
REQ-037 Rename x5 to nick 3, then x5 to nick 7; commit x5 with dt 0x11 and nick 3 -> data=0x11, the read still shows busy=1, nick=7.
REQ-038 In one cycle, commit x8 (nick 4, tag 4) and rename x8 to nick 9 -> next cycle busy=1, nick=9, and data[8] holds the committed value.
REQ-039 Tags on x1, x2, x3, then clr together with a rename of x4 to nick 5 -> next cycle all four ports/regs read busy=0 and x4 stays untagged.
REQ-040 Rename or commit x0 with dt 0xFFFF_FFFF -> x0 reads busy=0, dt=0; with rdy=0, a rename of x9 -> no tag change.
